// File: rtl/ccff_chain_loader.sv
// rtl/ccff_chain_loader.sv - serializes bitstream words onto a ccff chain while deserializing its tail into readback words
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 24,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [WORD_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [WORD_W-1:0] rd_data,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              shift_en
);

  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int IW = $clog2(WORD_W + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(CHAIN_LEN - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(CHAIN_LEN);
  localparam logic [IW-1:0] W_CNT    = IW'(WORD_W);
  localparam logic [IW-1:0] W_M1     = IW'(WORD_W - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     bit_cnt;
  logic [WORD_W-1:0] in_sr;
  logic [IW-1:0]     in_bits;
  logic [IW-1:0]     in_bits_ld;
  logic [WORD_W-1:0] cap_sr;
  logic [IW-1:0]     cap_bits;
  logic [WORD_W-1:0] cap_shifted;
  logic [IW-1:0]     cap_cnt_inc;
  logic              cap_full;
  logic              start_fire;
  logic              wr_fire;
  int                rem;

  function automatic logic [WORD_W-1:0] left_justify(input logic [WORD_W-1:0] v,
                                                     input logic [IW-1:0] n);
    logic [IW-1:0] sh;
    sh = W_CNT - n;
    return v << sh;
  endfunction

  assign cap_full    = (cap_bits == W_CNT);
  assign cap_shifted = {cap_sr[WORD_W-2:0], ccff_tail};
  assign cap_cnt_inc = cap_bits + IW'(1);
  assign wr_fire     = wr_valid && wr_ready;

  always_comb begin
    rem        = CHAIN_LEN - int'(bit_cnt);
    in_bits_ld = (rem >= WORD_W) ? W_CNT : IW'(rem);
  end

  always_comb begin
    state_nx   = state;
    shift_en   = 1'b0;
    ccff_head  = 1'b0;
    wr_ready   = 1'b0;
    busy       = (state != IDLE) || done;
    start_fire = (state == IDLE) && !done && start;
    case (state)
      IDLE: begin
        if (start_fire) state_nx = LOAD;
      end
      LOAD: begin
        wr_ready = (in_bits == '0) && (bit_cnt < FULL_CNT);
        // a full capture word with nowhere to go freezes the chain
        if ((in_bits != '0) && !(cap_full && rd_valid)) begin
          shift_en  = 1'b1;
          ccff_head = in_sr[WORD_W-1];
          if (bit_cnt == LAST_BIT) state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (rd_valid && rd_ready && (cap_bits == '0)) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      in_sr    <= '0;
      in_bits  <= '0;
      cap_sr   <= '0;
      cap_bits <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      done     <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= (state == DRAIN) && (state_nx == IDLE);
      if (start_fire) begin
        bit_cnt  <= '0;
        in_sr    <= '0;
        in_bits  <= '0;
        cap_sr   <= '0;
        cap_bits <= '0;
      end
      if (wr_fire) begin
        in_sr   <= wr_data;
        in_bits <= in_bits_ld;
      end
      if (rd_valid && rd_ready) rd_valid <= 1'b0;
      if (shift_en) begin
        in_sr   <= {in_sr[WORD_W-2:0], 1'b0};
        in_bits <= in_bits - IW'(1);
        bit_cnt <= bit_cnt + CW'(1);
        // completed words go straight to the holding register so rd_valid follows the last capture
        if (cap_full) begin
          rd_data  <= cap_sr;
          rd_valid <= 1'b1;
          cap_sr   <= {{(WORD_W-1){1'b0}}, ccff_tail};
          cap_bits <= IW'(1);
        end else if (((cap_bits == W_M1) || (bit_cnt == LAST_BIT)) && !rd_valid) begin
          rd_data  <= left_justify(cap_shifted, cap_cnt_inc);
          rd_valid <= 1'b1;
          cap_sr   <= '0;
          cap_bits <= '0;
        end else begin
          cap_sr   <= cap_shifted;
          cap_bits <= cap_cnt_inc;
        end
      end else if ((cap_bits != '0) && (cap_full || (bit_cnt == FULL_CNT)) && !rd_valid) begin
        rd_data  <= left_justify(cap_sr, cap_bits);
        rd_valid <= 1'b1;
        cap_sr   <= '0;
        cap_bits <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb/tb_ccff_chain_loader.sv - directed bench for ccff_chain_loader on a 24-flop and a 20-flop chain
module tb_ccff_chain_loader;

  logic prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  logic       pReset, start24, start20, wr_valid, rd_ready, sel;
  logic [7:0] wr_data;
  logic       busy24, done24, wr_ready24, rd_valid24, head24, shift24, tail24;
  logic       busy20, done20, wr_ready20, rd_valid20, head20, shift20, tail20;
  logic [7:0] rd_data24, rd_data20;

  ccff_chain_loader #(.CHAIN_LEN(24), .WORD_W(8)) u_dut24 (
    .prog_clk(prog_clk), .pReset(pReset), .start(start24), .busy(busy24), .done(done24),
    .wr_valid(wr_valid), .wr_ready(wr_ready24), .wr_data(wr_data),
    .rd_valid(rd_valid24), .rd_ready(rd_ready), .rd_data(rd_data24),
    .ccff_head(head24), .ccff_tail(tail24), .shift_en(shift24)
  );

  ccff_chain_loader #(.CHAIN_LEN(20), .WORD_W(8)) u_dut20 (
    .prog_clk(prog_clk), .pReset(pReset), .start(start20), .busy(busy20), .done(done20),
    .wr_valid(wr_valid), .wr_ready(wr_ready20), .wr_data(wr_data),
    .rd_valid(rd_valid20), .rd_ready(rd_ready), .rd_data(rd_data20),
    .ccff_head(head20), .ccff_tail(tail20), .shift_en(shift20)
  );

  // chain models: shift on gated edges, tail is the oldest flop
  logic [23:0] chain24 = '0;
  logic [19:0] chain20 = '0;
  always @(posedge prog_clk) begin
    if (shift24) chain24 <= {chain24[22:0], head24};
    if (shift20) chain20 <= {chain20[18:0], head20};
  end
  assign tail24 = chain24[23];
  assign tail20 = chain20[19];

  logic       busy_m, done_m, wr_ready_m, rd_valid_m, head_m, shift_m;
  logic [7:0] rd_data_m;
  assign busy_m     = sel ? busy20     : busy24;
  assign done_m     = sel ? done20     : done24;
  assign wr_ready_m = sel ? wr_ready20 : wr_ready24;
  assign rd_valid_m = sel ? rd_valid20 : rd_valid24;
  assign head_m     = sel ? head20     : head24;
  assign shift_m    = sel ? shift20    : shift24;
  assign rd_data_m  = sel ? rd_data20  : rd_data24;

  int         shifts = 0, dones = 0, head_bad = 0;
  bit         head_log[$];
  logic [7:0] rd_log[$];

  always @(negedge prog_clk) begin
    if (shift_m) begin
      shifts++;
      head_log.push_back(head_m);
    end else if (head_m) begin
      head_bad++;
    end
    if (rd_valid_m && rd_ready) rd_log.push_back(rd_data_m);
    if (done_m) dones++;
  end

  int n_checks = 0, n_fail = 0;
  int s_b, h_b, r_b, d_b, hb_b;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge prog_clk);
    #1;
  endtask

  task automatic snap();
    s_b  = shifts;
    h_b  = head_log.size();
    r_b  = rd_log.size();
    d_b  = dones;
    hb_b = head_bad;
  endtask

  task automatic do_start();
    if (sel) start20 = 1'b1;
    else start24 = 1'b1;
    cyc(1);
    start20 = 1'b0;
    start24 = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    bit ok = 1'b0;
    wr_valid = 1'b1;
    wr_data  = w;
    for (int i = 0; i < 200; i++) begin
      @(negedge prog_clk);
      if (wr_ready_m) begin
        ok = 1'b1;
        break;
      end
    end
    cyc(1);
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    check_val("wr_accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge prog_clk);
      if (done_m) begin
        ok = 1'b1;
        break;
      end
    end
    check_val("done_seen", 32'(ok), 32'd1);
    check_val("busy_with_done", 32'(busy_m), 32'd1);
    cyc(1);
    @(negedge prog_clk);
    check_val("busy_after_done", 32'(busy_m), 32'd0);
    cyc(1);
  endtask

  task automatic run_load(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2);
    do_start();
    send_word(w0);
    send_word(w1);
    send_word(w2);
    wait_done();
  endtask

  function automatic logic [31:0] head_word(input int base, input int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v = {v[30:0], head_log[base+i]};
    return v;
  endfunction

  task automatic check_result(input int nbits, input logic [31:0] exp_head, input bit chk_rd,
                              input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
    check_val("shift_count", shifts - s_b, nbits);
    check_val("head_bits", head_word(h_b, nbits), exp_head);
    check_val("done_count", dones - d_b, 32'd1);
    if (chk_rd) begin
      check_val("rd_count", rd_log.size() - r_b, 32'd3);
      check_val("rd_word0", 32'(rd_log[r_b]), 32'(e0));
      check_val("rd_word1", 32'(rd_log[r_b+1]), 32'(e1));
      check_val("rd_word2", 32'(rd_log[r_b+2]), 32'(e2));
    end
  endtask

  initial begin
    int cnt;
    int s_r;
    pReset = 1'b1; start24 = 1'b0; start20 = 1'b0; wr_valid = 1'b0;
    wr_data = 8'h00; rd_ready = 1'b1; sel = 1'b0;
    cyc(3);
    @(negedge prog_clk);
    check_val("rst_busy", 32'(busy24), 32'd0);
    check_val("rst_done", 32'(done24), 32'd0);
    check_val("rst_wr_ready", 32'(wr_ready24), 32'd0);
    check_val("rst_rd_valid", 32'(rd_valid24), 32'd0);
    check_val("rst_rd_data", 32'(rd_data24), 32'd0);
    check_val("rst_head", 32'(head24), 32'd0);
    check_val("rst_shift_en", 32'(shift24), 32'd0);
    check_val("rst_busy20", 32'(busy20), 32'd0);
    cyc(1);
    pReset = 1'b0;
    cyc(2);

    // nominal load into a zeroed chain, with start and word latency
    snap();
    do_start();
    @(negedge prog_clk);
    check_val("start_busy", 32'(busy_m), 32'd1);
    check_val("start_wr_ready", 32'(wr_ready_m), 32'd1);
    cyc(1);
    send_word(8'hA5);
    @(negedge prog_clk);
    check_val("word_latency", 32'(shift_m), 32'd1);
    cyc(1);
    send_word(8'h3C);
    send_word(8'hF0);
    wait_done();
    check_result(24, 32'h00A53CF0, 1'b1, 8'h00, 8'h00, 8'h00);

    snap();
    run_load(8'h12, 8'h34, 8'h56);
    check_result(24, 32'h00123456, 1'b1, 8'hA5, 8'h3C, 8'hF0);

    // partial final word on the 20-flop chain
    sel = 1'b1;
    cyc(1);
    snap();
    run_load(8'hFF, 8'hFF, 8'hFF);
    check_result(20, 32'h000FFFFF, 1'b1, 8'h00, 8'h00, 8'h00);
    snap();
    run_load(8'h00, 8'h00, 8'h00);
    check_result(20, 32'h00000000, 1'b1, 8'hFF, 8'hFF, 8'hF0);
    sel = 1'b0;
    cyc(1);

    // readback backpressure
    snap();
    rd_ready = 1'b0;
    do_start();
    send_word(8'h00);
    send_word(8'h00);
    send_word(8'h00);
    cyc(20);
    check_val("bp_shifts", shifts - s_b, 32'd16);
    @(negedge prog_clk);
    check_val("bp_shift_en", 32'(shift_m), 32'd0);
    check_val("bp_rd_valid", 32'(rd_valid_m), 32'd1);
    check_val("bp_rd_data", 32'(rd_data_m), 32'h12);
    cyc(8);
    @(negedge prog_clk);
    check_val("bp_rd_hold", 32'(rd_data_m), 32'h12);
    cyc(1);
    rd_ready = 1'b1;
    @(negedge prog_clk);
    check_val("bp_stall_at_hs", 32'(shift_m), 32'd0);
    @(negedge prog_clk);
    check_val("bp_resume", 32'(shift_m), 32'd1);
    cyc(1);
    wait_done();
    check_result(24, 32'h00000000, 1'b1, 8'h12, 8'h34, 8'h56);

    // input starvation between words
    snap();
    do_start();
    send_word(8'h5A);
    cyc(18);
    check_val("gap_shifts", shifts - s_b, 32'd8);
    @(negedge prog_clk);
    check_val("gap_shift_en", 32'(shift_m), 32'd0);
    check_val("gap_head", 32'(head_m), 32'd0);
    cyc(1);
    send_word(8'hC3);
    send_word(8'h96);
    wait_done();
    check_result(24, 32'h005AC396, 1'b1, 8'h00, 8'h00, 8'h00);
    check_val("gap_head_idle", head_bad - hb_b, 32'd0);

    // reset after nine shifts
    do_start();
    send_word(8'hFF);
    wr_valid = 1'b1;
    wr_data  = 8'hFF;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge prog_clk);
      if (shift_m) cnt++;
      if (cnt == 9) break;
    end
    #1;
    pReset   = 1'b1;
    wr_valid = 1'b0;
    check_val("rst_at9_shifts", cnt, 32'd9);
    cyc(1);
    @(negedge prog_clk);
    check_val("mid_rst_busy", 32'(busy_m), 32'd0);
    check_val("mid_rst_shift_en", 32'(shift_m), 32'd0);
    check_val("mid_rst_wr_ready", 32'(wr_ready_m), 32'd0);
    check_val("mid_rst_rd_valid", 32'(rd_valid_m), 32'd0);
    check_val("mid_rst_rd_data", 32'(rd_data_m), 32'd0);
    check_val("mid_rst_head", 32'(head_m), 32'd0);
    check_val("mid_rst_done", 32'(done_m), 32'd0);
    cyc(1);
    pReset = 1'b0;
    s_r = shifts;
    cyc(4);
    check_val("no_shift_after_rst", shifts - s_r, 32'd0);
    snap();
    run_load(8'h81, 8'h42, 8'h24);
    check_result(24, 32'h00814224, 1'b0, 8'h00, 8'h00, 8'h00);

    // protocol misuse: wr_valid in IDLE, start during a load
    snap();
    wr_valid = 1'b1;
    wr_data  = 8'hEE;
    @(negedge prog_clk);
    check_val("idle_wr_ready", 32'(wr_ready_m), 32'd0);
    cyc(1);
    wr_valid = 1'b0;
    cyc(2);
    check_val("idle_wr_no_shift", shifts - s_b, 32'd0);
    check_val("idle_wr_busy", 32'(busy_m), 32'd0);
    do_start();
    send_word(8'h11);
    cyc(3);
    start24 = 1'b1;
    cyc(1);
    start24 = 1'b0;
    send_word(8'h22);
    send_word(8'h33);
    wait_done();
    check_result(24, 32'h00112233, 1'b1, 8'h81, 8'h42, 8'h24);
    s_r = shifts;
    cyc(5);
    check_val("no_restart_shifts", shifts - s_r, 32'd0);
    check_val("no_restart_busy", 32'(busy_m), 32'd0);
    check_val("head_idle_zero", head_bad, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
